// File: rtl/wb_merge_if.sv
// Bundle of execute/load inputs and register-file write outputs for wb_merge.
// Compile-time option in the consumer: WB_BYPASS_EN (load bypass into the write register).
interface wb_merge_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic                           ex_valid;
  logic                           ex_ready;
  logic [ADDR_WIDTH-1:0]          ex_rd;
  logic [DATA_WIDTH-1:0]          ex_data;
  logic                           mem_valid;
  logic                           mem_ready;
  logic [ADDR_WIDTH-1:0]          mem_rd;
  logic [DATA_WIDTH-1:0]          mem_data;
  logic                           wen;
  logic [ADDR_WIDTH-1:0]          waddr;
  logic [DATA_WIDTH-1:0]          wdata;
  logic [(1<<ADDR_WIDTH)-1:0]     rd_pending;
  logic [31:0]                    wb_cnt;

  modport master (
    output ex_valid, ex_rd, ex_data, mem_valid, mem_rd, mem_data,
    input  ex_ready, mem_ready, wen, waddr, wdata, rd_pending, wb_cnt
  );

  modport slave (
    input  ex_valid, ex_rd, ex_data, mem_valid, mem_rd, mem_data,
    output ex_ready, mem_ready, wen, waddr, wdata, rd_pending, wb_cnt
  );
endinterface

// File: rtl/wb_merge.sv
// Writeback merge: arbitrates execute results and queued load returns onto one
// registered register-file write port. Define WB_BYPASS_EN to let loads skip an empty queue.
module wb_merge #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned LQ_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  wb_merge_if.slave   bus
);

  localparam int unsigned PTR_W = $clog2(LQ_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned REG_N = 1 << ADDR_WIDTH;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] data;
  } lq_entry_t;

  lq_entry_t             lq_mem [LQ_DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;

  logic                  wen_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [31:0]           wb_cnt_q;

  logic                  full_c;
  logic                  ex_fire_c;
  logic                  mem_fire_c;
  logic                  enq_c;
  logic                  deq_c;
  logic                  out_vld_c;
  lq_entry_t             out_c;
  logic [REG_N-1:0]      pend_c;

  // Output selection: a full queue drains first so loads cannot starve behind execute.
  always_comb begin
    full_c     = (count == CNT_W'(LQ_DEPTH));
    ex_fire_c  = bus.ex_valid && !full_c;
    mem_fire_c = bus.mem_valid && !full_c;
    enq_c      = mem_fire_c;
    deq_c      = 1'b0;
    out_vld_c  = 1'b0;
    out_c      = lq_mem[head];
    if (full_c) begin
      deq_c     = 1'b1;
      out_vld_c = 1'b1;
    end else if (ex_fire_c) begin
      out_vld_c = 1'b1;
      out_c     = '{rd: bus.ex_rd, data: bus.ex_data};
    end else if (count != '0) begin
      deq_c     = 1'b1;
      out_vld_c = 1'b1;
    end
`ifdef WB_BYPASS_EN
    else if (mem_fire_c) begin
      out_vld_c = 1'b1;
      enq_c     = 1'b0;
      out_c     = '{rd: bus.mem_rd, data: bus.mem_data};
    end
`endif
  end

  // Queue storage carries no reset; validity comes from head/count.
  always_ff @(posedge clk) begin
    if (enq_c) begin
      lq_mem[tail] <= '{rd: bus.mem_rd, data: bus.mem_data};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq_c) begin
        tail <= tail + PTR_W'(1);
      end
      if (deq_c) begin
        head <= head + PTR_W'(1);
      end
      count <= count + CNT_W'(enq_c) - CNT_W'(deq_c);
    end
  end

  // Write register; rd=0 results are consumed but never written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wb_cnt_q <= '0;
    end else begin
      wen_q    <= out_vld_c && (out_c.rd != '0);
      wb_cnt_q <= wb_cnt_q + 32'(wen_q);
      if (out_vld_c && (out_c.rd != '0)) begin
        waddr_q <= out_c.rd;
        wdata_q <= out_c.data;
      end
    end
  end

  // Pending mask over live entries: slot i is live when (i - head) mod depth < count.
  always_comb begin
    logic [PTR_W-1:0] offs;
    pend_c = '0;
    offs   = '0;
    for (int unsigned i = 0; i < LQ_DEPTH; i++) begin
      offs = PTR_W'(i) - head;
      if (({1'b0, offs} < count) && (lq_mem[i].rd != '0)) begin
        pend_c[lq_mem[i].rd] = 1'b1;
      end
    end
  end

  assign bus.ex_ready   = !full_c;
  assign bus.mem_ready  = !full_c;
  assign bus.wen        = wen_q;
  assign bus.waddr      = waddr_q;
  assign bus.wdata      = wdata_q;
  assign bus.wb_cnt     = wb_cnt_q;
  assign bus.rd_pending = pend_c;

endmodule

// File: doc/wb_merge.md
# wb_merge

Writeback merge stage that sits directly upstream of the register file write port. It accepts single-cycle results from the execute stage and variable-latency load returns from the memory interface. It queues loads in a small in-order FIFO and issues at most one registered write (wen/waddr/wdata) per cycle to the register file. It also exports a pending-destination mask for hazard detection and a writeback counter.

## Interface
- DATA_WIDTH, 32, width of result data
- ADDR_WIDTH, 5, width of destination register index
- LQ_DEPTH, 4, load-queue entries (power of two, ≥2)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- ex_valid  in  1  execute result present
- ex_ready  out  1  execute result accepted this cycle when ex_valid&&ex_ready
- ex_rd  in  ADDR_WIDTH  execute destination register
- ex_data  in  DATA_WIDTH  execute result
- mem_valid  in  1  load return present
- mem_ready  out  1  load return accepted when mem_valid&&mem_ready
- mem_rd  in  ADDR_WIDTH  load destination register
- mem_data  in  DATA_WIDTH  load data
- wen  out  1  register-file write enable (registered)
- waddr  out  ADDR_WIDTH  register-file write address (registered)
- wdata  out  DATA_WIDTH  register-file write data (registered)
- rd_pending  out  2^ADDR_WIDTH  bit r set iff a valid queue entry targets r (r≠0)
- wb_cnt  out  32  number of cycles with wen=1 since reset

## Operation
- Load queue: circular FIFO with head and tail pointers plus a count (0..LQ_DEPTH). Order is preserved.
- ex_ready = mem_ready = (count < LQ_DEPTH), derived from registered count only.
- Enqueue: when mem_valid&&mem_ready and the load is not bypassed, write it at tail.
- Per-cycle output selection, in priority order:
  1. count==LQ_DEPTH: dequeue head to output. ex_ready=0, which prevents starvation.
  2. ex_valid&&ex_ready: execute result to output. The queue does not dequeue.
  3. count>0: dequeue head to output.
  4. Bypass case (config only): load goes straight to output.
  5. Otherwise: output register loads wen=0.
- Enqueue and dequeue may occur in the same cycle.
  - count is unchanged.
  - A load entering an empty queue cannot be dequeued in the same cycle.
- rd=0 results are consumed normally but produce wen=0. They do not count in wb_cnt and do not set rd_pending.
- When wen=0, waddr and wdata hold their previous values.
- rd_pending is combinational from queue valid bits and entry rd fields.
- wb_cnt increments by 1 on each cycle in which wen=1 and wraps from 2^32−1 to 0.

## Timing
- Reset (rst low, asynchronous) values:
  - wen=0, waddr=0, wdata=0
  - count=0, head=tail=0
  - rd_pending=0, wb_cnt=0
  - ex_ready=1, mem_ready=1
- Reset mid-operation discards all queued loads. The output register is cleared immediately, without waiting for a clock edge.
- Execute path latency: accepted at edge N, wen=1 during cycle N..N+1, register file written at edge N+1.
- Load path latency (no bypass): enqueued at edge N, earliest dequeue at edge N+1, wen visible after edge N+1.
- Throughput: one write per cycle sustained.

## Configuration
- WB_BYPASS_EN defined: a load with mem_valid, count==0 and no accepted execute result goes directly to the output register at edge N without being enqueued. Latency matches the execute path.
- Not defined: every load passes through the queue, so its latency is one cycle more than the execute path.

## Test plan
- Reset check: hold rst low 3 cycles, then release.
  - Required: wen=0, waddr=0, wdata=0, wb_cnt=0, rd_pending=0, ex_ready=mem_ready=1.
- Execute only: ex_rd=5, ex_data=0xDEADBEEF for 1 cycle.
  - Required: next cycle wen=1, waddr=5, wdata=0xDEADBEEF, then wb_cnt=1.
- Queue fill and starvation guard:
  - Stimulus: 4 loads with rd=1..4 and data 0x10..0x13 while ex_valid is held with rd=9.
  - Required: ex wins each cycle until count=4. Then ex_ready=0, loads drain in order 1,2,3,4, and rd_pending falls from 0x1E to 0.
- Simultaneous events: mem_valid and ex_valid in the same cycle with count=1.
  - Required: ex written first, head dequeued next cycle, new load after it. Order ex, old, new.
- rd=0 drop: ex_rd=0, ex_data=0x1234.
  - Required: ex_ready=1, wen stays 0, wb_cnt unchanged.
- Bypass and reset abort: load rd=7, data 0x55 into an empty queue.
  - Required with WB_BYPASS_EN: wen=1 one cycle after acceptance. Without it: two cycles after.
  - Then fill 3 entries and assert rst: count returns to 0, and no further writes are issued.
